div_bf16_seq: RTL and testbench



---
 rtl/div_bf16_seq.sv | 229 ++++++++++++++++++++++
 tb/tb_div_bf16_seq.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/div_bf16_seq.sv
// Iterative BF16 divider: bf1_in / bf2_in.
// Radix-2 restoring mantissa division produces one quotient bit per cycle.
// The result is rounded to nearest-even. Special operands skip the divide loop.
// Optional macro DIV_BF16_DBZ_FLAG_EN adds a div_by_zero flag output.
module div_bf16_seq #(
  parameter int          EXP_BIAS = 127,
  parameter logic [15:0] QNAN     = 16'h7FC0
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        start,
  input  logic [15:0] bf1_in,
  input  logic [15:0] bf2_in,
  output logic [15:0] bf_out,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic        underflow,
  output logic        invalid
`ifdef DIV_BF16_DBZ_FLAG_EN
  ,output logic       div_by_zero
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_RND} state_t;

  state_t             r_state, w_next;
  logic               r_sign;
  logic signed [9:0]  r_exp;
  logic [9:0]         r_rem, r_div, r_q;
  logic [3:0]         r_cnt;
  logic               r_spec, r_spec_inv;
  logic [15:0]        r_spec_res;
  logic [15:0]        r_bf_out;
  logic               r_done, r_ovf, r_unf, r_inv;
`ifdef DIV_BF16_DBZ_FLAG_EN
  logic               r_spec_dbz, r_dbz;
`endif

  // ---------------- operand decode ----------------
  logic [7:0] w_e1, w_e2;
  logic [6:0] w_m1, w_m2;
  logic       w_zero1, w_zero2, w_inf1, w_inf2, w_nan1, w_nan2;
  logic       w_sign, w_special;
  logic [9:0] w_exp_diff;

  assign w_e1    = bf1_in[14:7];
  assign w_m1    = bf1_in[6:0];
  assign w_e2    = bf2_in[14:7];
  assign w_m2    = bf2_in[6:0];
  // Subnormals (exponent 0) are flushed: they count as zero.
  assign w_zero1 = (w_e1 == 8'h00);
  assign w_zero2 = (w_e2 == 8'h00);
  assign w_inf1  = (w_e1 == 8'hFF) && (w_m1 == 7'h0);
  assign w_inf2  = (w_e2 == 8'hFF) && (w_m2 == 7'h0);
  assign w_nan1  = (w_e1 == 8'hFF) && (w_m1 != 7'h0);
  assign w_nan2  = (w_e2 == 8'hFF) && (w_m2 != 7'h0);
  assign w_sign  = bf1_in[15] ^ bf2_in[15];
  assign w_special = w_nan1 | w_nan2 | w_zero1 | w_zero2 | w_inf1 | w_inf2;
  assign w_exp_diff = {2'b00, w_e1} - {2'b00, w_e2} + 10'(EXP_BIAS);

  // Special-case result, resolved in priority order (invalid first).
  logic [15:0] w_spec_res;
  logic        w_spec_inv, w_spec_dbz;
  always_comb begin
    w_spec_res = {w_sign, 15'h0};
    w_spec_inv = 1'b0;
    w_spec_dbz = 1'b0;
    if (w_nan1 | w_nan2 | (w_zero1 & w_zero2) | (w_inf1 & w_inf2)) begin
      w_spec_res = QNAN;
      w_spec_inv = 1'b1;
    end else if (w_inf1) begin
      w_spec_res = {w_sign, 8'hFF, 7'h0};
    end else if (w_inf2) begin
      w_spec_res = {w_sign, 15'h0};
    end else if (w_zero2) begin
      w_spec_res = {w_sign, 8'hFF, 7'h0};
      w_spec_dbz = 1'b1;
    end
  end

  // ---------------- divide step ----------------
  logic       w_ge;
  logic [9:0] w_rem_sub;
  assign w_ge      = (r_rem >= r_div);
  assign w_rem_sub = w_ge ? (r_rem - r_div) : r_rem;

  // ---------------- normalise + round ----------------
  logic [6:0]        w_frac_pre, w_frac_fin;
  logic              w_g, w_s, w_rnd_up;
  logic [7:0]        w_frac_sum;
  logic signed [9:0] w_exp_pre, w_exp_rnd;
  logic              w_ovf, w_unf;
  logic [15:0]       w_norm_res;

  // Quotient is in (0.5, 2): q[9] selects which bits form the mantissa.
  always_comb begin
    if (r_q[9]) begin
      w_frac_pre = r_q[8:2];
      w_g        = r_q[1];
      w_s        = r_q[0] | (r_rem != 10'd0);
      w_exp_pre  = r_exp;
    end else begin
      w_frac_pre = r_q[7:1];
      w_g        = r_q[0];
      w_s        = (r_rem != 10'd0);
      w_exp_pre  = r_exp - 10'sd1;
    end
  end

  assign w_rnd_up   = w_g & (w_s | w_frac_pre[0]);
  assign w_frac_sum = {1'b0, w_frac_pre} + {7'd0, w_rnd_up};
  assign w_frac_fin = w_frac_sum[7] ? 7'h0 : w_frac_sum[6:0];
  assign w_exp_rnd  = w_exp_pre + {9'd0, w_frac_sum[7]};
  assign w_ovf      = (w_exp_rnd >= 10'sd255);
  assign w_unf      = (w_exp_rnd <= 10'sd0);

  // Saturate to inf on overflow and flush to zero on underflow.
  always_comb begin
    if (w_ovf)      w_norm_res = {r_sign, 8'hFF, 7'h0};
    else if (w_unf) w_norm_res = {r_sign, 15'h0};
    else            w_norm_res = {r_sign, w_exp_rnd[7:0], w_frac_fin};
  end

  // ---------------- FSM ----------------
  // State register.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic. start is only sampled in IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = w_special ? S_RND : S_DIV;
      S_DIV:  if (r_cnt == 4'd9) w_next = S_RND;
      S_RND:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: operand latch, divide iterations, result/flag registers.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_sign     <= 1'b0;
      r_exp      <= '0;
      r_rem      <= '0;
      r_div      <= '0;
      r_q        <= '0;
      r_cnt      <= '0;
      r_spec     <= 1'b0;
      r_spec_inv <= 1'b0;
      r_spec_res <= '0;
      r_bf_out   <= '0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
      r_inv      <= 1'b0;
`ifdef DIV_BF16_DBZ_FLAG_EN
      r_spec_dbz <= 1'b0;
      r_dbz      <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sign     <= w_sign;
            r_exp      <= w_exp_diff;
            r_rem      <= {2'b01, w_m1, 1'b0} >> 1;
            r_div      <= {2'b01, w_m2, 1'b0} >> 1;
            r_q        <= '0;
            r_cnt      <= '0;
            r_spec     <= w_special;
            r_spec_inv <= w_spec_inv;
            r_spec_res <= w_spec_res;
`ifdef DIV_BF16_DBZ_FLAG_EN
            r_spec_dbz <= w_spec_dbz;
`endif
          end
        end
        S_DIV: begin
          r_q   <= {r_q[8:0], w_ge};
          r_rem <= {w_rem_sub[8:0], 1'b0};
          r_cnt <= r_cnt + 4'd1;
        end
        S_RND: begin
          r_done <= 1'b1;
          if (r_spec) begin
            r_bf_out <= r_spec_res;
            r_inv    <= r_spec_inv;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
`ifdef DIV_BF16_DBZ_FLAG_EN
            r_dbz    <= r_spec_dbz;
`endif
          end else begin
            r_bf_out <= w_norm_res;
            r_inv    <= 1'b0;
            r_ovf    <= w_ovf;
            r_unf    <= w_unf;
`ifdef DIV_BF16_DBZ_FLAG_EN
            r_dbz    <= 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

`ifndef DIV_BF16_DBZ_FLAG_EN
  // Divide-by-zero still yields inf; only the flag output is absent.
  logic w_unused;
  assign w_unused = w_spec_dbz;
`endif

  assign bf_out    = r_bf_out;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign overflow  = r_ovf;
  assign underflow = r_unf;
  assign invalid   = r_inv;
`ifdef DIV_BF16_DBZ_FLAG_EN
  assign div_by_zero = r_dbz;
`endif

endmodule

// File: tb/tb_div_bf16_seq.sv
// Scoreboard bench for div_bf16_seq: the driver pushes expected results,
// and the monitor pops and compares each one on a done pulse.
module tb_div_bf16_seq;

  logic        clk = 1'b0;
  logic        nRST = 1'b0;
  logic        start = 1'b0;
  logic [15:0] bf1_in = '0, bf2_in = '0;
  logic [15:0] bf_out;
  logic        busy, done, overflow, underflow, invalid;
`ifdef DIV_BF16_DBZ_FLAG_EN
  logic        div_by_zero;
`endif

  div_bf16_seq dut (
    .clk(clk), .nRST(nRST), .start(start),
    .bf1_in(bf1_in), .bf2_in(bf2_in),
    .bf_out(bf_out), .busy(busy), .done(done),
    .overflow(overflow), .underflow(underflow), .invalid(invalid)
`ifdef DIV_BF16_DBZ_FLAG_EN
    ,.div_by_zero(div_by_zero)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       nm;
    logic [15:0] res;
    logic [2:0]  flg;   // {overflow, underflow, invalid}
    logic        dbz;
    int          lat;
    int          scyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_pass = 0;
  int   n_tot  = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    n_tot++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, req);
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (nRST && done) begin
      if (sb.size() == 0) begin
        n_tot++;
        $display("FAIL unexpected_done: got done=1 want no pending result (bf_out=%h)", bf_out);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.nm, "_res"}, bf_out, mon_e.res);
        chk({mon_e.nm, "_flags"}, {13'd0, overflow, underflow, invalid}, {13'd0, mon_e.flg});
        chk({mon_e.nm, "_lat"}, 16'(cyc - mon_e.scyc), 16'(mon_e.lat));
`ifdef DIV_BF16_DBZ_FLAG_EN
        chk({mon_e.nm, "_dbz"}, {15'd0, div_by_zero}, {15'd0, mon_e.dbz});
`endif
      end
    end
  end

  // Drive one request for a single cycle and record its expected response.
  task automatic issue(input string nm, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] res, input logic [2:0] flg, input logic dbz,
                       input int lat);
    exp_t e;
    @(negedge clk);
    start = 1'b1; bf1_in = a; bf2_in = b;
    e.nm = nm; e.res = res; e.flg = flg; e.dbz = dbz; e.lat = lat; e.scyc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_tot++;
      $display("FAIL timeout: got %0d results pending want 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    logic busy_ok;
    exp_t e;
    // Reset state.
    #12;
    chk("rst_bf_out", bf_out, 16'h0);
    chk("rst_ctrl", {11'd0, busy, done, overflow, underflow, invalid}, 16'h0);
    nRST = 1'b1;
    repeat (2) @(negedge clk);

    // 1.5 / 0.75 with busy tracking across the 11 cycles.
    issue("div_1p5_0p75", 16'h3FC0, 16'h3F40, 16'h4000, 3'b000, 1'b0, 11);
    busy_ok = busy;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      busy_ok = busy_ok & busy;
    end
    chk("busy_during_div", {15'd0, busy_ok}, 16'd1);
    wait_drain();

    issue("div_1_3",     16'h3F80, 16'h4040, 16'h3EAB, 3'b000, 1'b0, 11); wait_drain();
    issue("div_1_1p5",   16'h3F80, 16'h3FC0, 16'h3F2B, 3'b000, 1'b0, 11); wait_drain();
    issue("div_3_m1",    16'h4040, 16'hBF80, 16'hC040, 3'b000, 1'b0, 11); wait_drain();
    issue("div_0_0",     16'h0000, 16'h0000, 16'h7FC0, 3'b001, 1'b0, 1);  wait_drain();
    issue("div_unf",     16'h0080, 16'h4000, 16'h0000, 3'b010, 1'b0, 11); wait_drain();
    issue("div_ovf",     16'h7F00, 16'h0080, 16'h7F80, 3'b100, 1'b0, 11); wait_drain();
    issue("div_dbz",     16'hBF80, 16'h0000, 16'hFF80, 3'b000, 1'b1, 1);  wait_drain();
    issue("div_nan",     16'h7FC1, 16'h3F80, 16'h7FC0, 3'b001, 1'b0, 1);  wait_drain();
    issue("div_inf_inf", 16'h7F80, 16'h7F80, 16'h7FC0, 3'b001, 1'b0, 1);  wait_drain();
    issue("div_inf_fin", 16'h7F80, 16'hBF80, 16'hFF80, 3'b000, 1'b0, 1);  wait_drain();
    issue("div_fin_inf", 16'h3F80, 16'hFF80, 16'h8000, 3'b000, 1'b0, 1);  wait_drain();
    issue("div_sub_fin", 16'h0001, 16'h3F80, 16'h0000, 3'b000, 1'b0, 1);  wait_drain();

    // A start pulse mid-DIV must be ignored.
    issue("div_mid_start", 16'h3F80, 16'h4040, 16'h3EAB, 3'b000, 1'b0, 11);
    repeat (3) @(negedge clk);
    start = 1'b1; bf1_in = 16'h0000; bf2_in = 16'h0000;
    @(negedge clk);
    start = 1'b0;
    wait_drain();
    repeat (5) @(negedge clk);

    // A start issued in the done cycle is accepted.
    issue("b2b_first", 16'h3F80, 16'h3F80, 16'h3F80, 3'b000, 1'b0, 11);
    for (int i = 0; i < 20 && !done; i++) @(negedge clk);
    start = 1'b1; bf1_in = 16'h4000; bf2_in = 16'h3F80;
    e.nm = "b2b_second"; e.res = 16'h4000; e.flg = 3'b000; e.dbz = 1'b0;
    e.lat = 11; e.scyc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    wait_drain();

    // Reset mid-operation aborts the operation with no done pulse.
    @(negedge clk);
    start = 1'b1; bf1_in = 16'h3FC0; bf2_in = 16'h3F40;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    nRST = 1'b0;
    #1;
    chk("midrst_bf_out", bf_out, 16'h0);
    chk("midrst_ctrl", {11'd0, busy, done, overflow, underflow, invalid}, 16'h0);
    repeat (2) @(negedge clk);
    nRST = 1'b1;
    repeat (15) @(negedge clk);
    issue("post_rst", 16'h3FC0, 16'h3F40, 16'h4000, 3'b000, 1'b0, 11);
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
